// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage hazard unit built on a per-register countdown
// scoreboard. Each in-flight write keeps its register busy for LAT_ALU or
// LAT_LOAD cycles; a reader of a busy register stalls in ID.
module hazard_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int LAT_ALU  = 2,
    parameter int LAT_LOAD = 2,
    parameter int R0_ZERO  = 0,
    parameter int STAT_W   = 16,
    localparam int REG_AW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic                rs_used,
    input  logic                rt_used,
    input  logic [REG_AW-1:0]   rs_addr,
    input  logic [REG_AW-1:0]   rt_addr,
    input  logic                rd_write,
    input  logic [REG_AW-1:0]   rd_addr,
    input  logic                rd_is_load,
    input  logic                freeze,
    input  logic                flush,
    input  logic                stat_clr,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy,
    output logic [STAT_W-1:0]   stall_cycles
);

    localparam int LAT_MAX = (LAT_ALU > LAT_LOAD) ? LAT_ALU : LAT_LOAD;
    localparam int CW      = (LAT_MAX > 0) ? $clog2(LAT_MAX + 1) : 1;

    logic [NUM_REGS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [STAT_W-1:0]           stall_cycles_q, stall_cycles_d;
    logic                        r0z;
    logic                        rs_hit, rt_hit, issue;
    logic [CW-1:0]               lat;

    assign r0z = (R0_ZERO != 0);

    // Pending flag per register is simply "countdown not yet expired".
    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++) busy[r] = |cnt_q[r];
    end

    // Sources are checked against current state, so an instruction never
    // stalls on its own destination. Register 0 is exempt when hardwired.
    always_comb begin
        rs_hit = rs_used && busy[rs_addr] && !(r0z && rs_addr == '0);
        rt_hit = rt_used && busy[rt_addr] && !(r0z && rt_addr == '0);
        stall  = id_valid && !flush && (rs_hit || rt_hit);
        issue  = id_valid && !stall && !freeze && !flush && rd_write &&
                 !(r0z && rd_addr == '0);
        lat    = rd_is_load ? CW'(LAT_LOAD) : CW'(LAT_ALU);
    end

    // Countdown update: hold on freeze, otherwise decrement; a new write
    // takes the longer of its latency and the remaining window (WAW safe).
    always_comb begin
        cnt_d = cnt_q;
        if (!freeze) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_d[r] = cnt_q[r] - CW'(|cnt_q[r]);
                if (issue && rd_addr == REG_AW'(r) && lat > cnt_d[r])
                    cnt_d[r] = lat;
            end
        end
    end

    // Stall statistics: clear wins, frozen cycles are not counted, saturate.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stat_clr)
            stall_cycles_d = '0;
        else if (stall && !freeze && !(&stall_cycles_q))
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    // State registers; reset clears all pending windows without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Three instances with different
// parameter sets share the same stimulus; each step checks the instance
// whose configuration the scenario targets.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, rs_used, rt_used, rd_write, rd_is_load;
    logic freeze, flush, stat_clr;
    logic [2:0] rs_addr, rt_addr, rd_addr;

    logic        stall_a, stall_b, stall_c;
    logic [7:0]  busy_a, busy_b, busy_c;
    logic [15:0] sc_a, sc_b;
    logic [3:0]  sc_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // A: LAT 2/2, no forwarding
    hazard_scoreboard #(.NUM_REGS(8), .LAT_ALU(2), .LAT_LOAD(2), .R0_ZERO(0), .STAT_W(16)) u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .rs_used(rs_used), .rt_used(rt_used),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_write(rd_write), .rd_addr(rd_addr),
        .rd_is_load(rd_is_load), .freeze(freeze), .flush(flush), .stat_clr(stat_clr),
        .stall(stall_a), .busy(busy_a), .stall_cycles(sc_a));

    // B: full forwarding with load-use bubble
    hazard_scoreboard #(.NUM_REGS(8), .LAT_ALU(0), .LAT_LOAD(1), .R0_ZERO(0), .STAT_W(16)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .rs_used(rs_used), .rt_used(rt_used),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_write(rd_write), .rd_addr(rd_addr),
        .rd_is_load(rd_is_load), .freeze(freeze), .flush(flush), .stat_clr(stat_clr),
        .stall(stall_b), .busy(busy_b), .stall_cycles(sc_b));

    // C: ALU 1 / LOAD 2, hardwired r0, narrow counter
    hazard_scoreboard #(.NUM_REGS(8), .LAT_ALU(1), .LAT_LOAD(2), .R0_ZERO(1), .STAT_W(4)) u_c (
        .clk(clk), .rst(rst), .id_valid(id_valid), .rs_used(rs_used), .rt_used(rt_used),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_write(rd_write), .rd_addr(rd_addr),
        .rd_is_load(rd_is_load), .freeze(freeze), .flush(flush), .stat_clr(stat_clr),
        .stall(stall_c), .busy(busy_c), .stall_cycles(sc_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic rsu, input int rsa, input logic rtu,
                       input int rta, input logic rdw, input int rda, input logic ld);
        id_valid   = v;
        rs_used    = rsu;
        rs_addr    = rsa[2:0];
        rt_used    = rtu;
        rt_addr    = rta[2:0];
        rd_write   = rdw;
        rd_addr    = rda[2:0];
        rd_is_load = ld;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        freeze   = 0;
        flush    = 0;
        stat_clr = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        #2;
        rst = 0;
        #1;
    endtask

    initial begin
        rst = 1;
        idle();
        tick();
        rst = 0;
        #1;
        // reset state
        chk("rst_stall_a", stall_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_sc_a", sc_a, 0);
        chk("rst_busy_c", busy_c, 0);

        // 1: ALU r3 then dependent reader, LAT 2
        drv(1, 0, 0, 0, 0, 1, 3, 0);
        #1 chk("t1_issue_nostall", stall_a, 0);
        tick();
        chk("t1_busy3_set", busy_a[3], 1);
        drv(1, 1, 3, 0, 0, 1, 4, 0);
        #1 chk("t1_stall_c1", stall_a, 1);
        tick();
        chk("t1_stall_c2", stall_a, 1);
        chk("t1_busy3_c2", busy_a[3], 1);
        tick();
        chk("t1_proceed", stall_a, 0);
        chk("t1_busy3_clr", busy_a[3], 0);
        tick();
        chk("t1_sc", sc_a, 2);
        chk("t1_busy4", busy_a, 8'h10);
        idle();

        // 2: forwarding config, load-use bubble only
        do_reset();
        drv(1, 0, 0, 0, 0, 1, 2, 1);
        tick();
        drv(1, 1, 2, 0, 0, 1, 5, 0);
        #1 chk("t2_loaduse_stall", stall_b, 1);
        tick();
        chk("t2_loaduse_go", stall_b, 0);
        tick();
        chk("t2_alu_nobusy", busy_b, 0);
        drv(1, 1, 5, 0, 0, 1, 6, 0);
        #1 chk("t2_alu_nostall", stall_b, 0);
        chk("t2_sc", sc_b, 1);
        idle();

        // 3: freeze holds the scoreboard and the stall statistic
        do_reset();
        drv(1, 0, 0, 0, 0, 1, 3, 0);
        tick();
        drv(1, 1, 3, 0, 0, 0, 0, 0);
        freeze = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t3_frz_stall", stall_a, 1);
            tick();
            chk("t3_frz_busy", busy_a[3], 1);
        end
        chk("t3_frz_sc", sc_a, 0);
        freeze = 0;
        #1 chk("t3_rel_stall1", stall_a, 1);
        tick();
        chk("t3_rel_stall2", stall_a, 1);
        chk("t3_rel_sc1", sc_a, 1);
        tick();
        chk("t3_rel_go", stall_a, 0);
        chk("t3_rel_sc2", sc_a, 2);

        // 6a: asynchronous reset mid-stall (counter carries 2 from above)
        drv(1, 0, 0, 0, 0, 1, 6, 0);
        tick();
        drv(1, 1, 6, 0, 0, 0, 0, 0);
        #1 chk("t6_pre_stall", stall_a, 1);
        chk("t6_pre_sc", sc_a, 2);
        rst = 1;
        #1;
        chk("t6_async_stall", stall_a, 0);
        chk("t6_async_busy", busy_a, 0);
        chk("t6_async_sc", sc_a, 0);
        rst = 0;
        idle();
        #1;

        // 4: WAW on r1 and flush with rt hazard (config C)
        do_reset();
        drv(1, 0, 0, 0, 0, 1, 1, 1);
        tick();
        drv(1, 0, 0, 0, 0, 1, 1, 0);
        #1 chk("t4_waw_nostall", stall_c, 0);
        tick();
        chk("t4_waw_busy1", busy_c, 8'h02);
        idle();
        tick();
        chk("t4_waw_expire", busy_c[1], 0);
        drv(1, 0, 0, 0, 0, 1, 1, 1);
        tick();
        drv(1, 0, 0, 1, 1, 1, 2, 0);
        flush = 1;
        #1 chk("t4_flush_nostall", stall_c, 0);
        tick();
        chk("t4_flush_noissue", busy_c, 8'h02);
        idle();

        // 5: hardwired r0 and unused Rt
        do_reset();
        drv(1, 0, 0, 0, 0, 1, 0, 1);
        tick();
        chk("t5_r0_notbusy", busy_c, 0);
        drv(1, 1, 0, 1, 0, 0, 0, 0);
        #1 chk("t5_r0_nostall", stall_c, 0);
        drv(1, 0, 0, 0, 0, 1, 7, 0);
        tick();
        drv(1, 0, 0, 0, 7, 0, 0, 0);
        #1 chk("t5_rt_unused", stall_c, 0);
        rt_used = 1;
        #1 chk("t5_rt_used", stall_c, 1);
        idle();
        tick();

        // 6b: saturating counter on STAT_W=4, then clear
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drv(1, 0, 0, 0, 0, 1, 1, 1);
            tick();
            drv(1, 1, 1, 0, 0, 0, 0, 0);
            tick();
            tick();
            if (i == 6) chk("t6_sc14", sc_c, 14);
            if (i == 7) chk("t6_sc_sat", sc_c, 15);
        end
        chk("t6_sc_hold", sc_c, 15);
        drv(1, 0, 0, 0, 0, 1, 1, 1);
        tick();
        drv(1, 1, 1, 0, 0, 0, 0, 0);
        stat_clr = 1;
        #1 chk("t6_clr_stall", stall_c, 1);
        tick();
        chk("t6_clr", sc_c, 0);
        stat_clr = 0;
        tick();
        chk("t6_after_clr", sc_c, 1);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
